mlx_frame_sequencer: RTL
========================

MLX_FRAME_SEQUENCER -- requirements
Module: mlx_frame_sequencer

Interface
REQ-001 Parameter SLAVE_ADDR, 7'h33, I2C slave address of the thermal sensor.
REQ-002 Parameter BURST_WIDTH, 4, width of the command burst field; burst length is 2^BURST_WIDTH words.
REQ-003 Parameter FRAME_WORDS, 832, frame RAM words per frame; SHALL be a multiple of 2^BURST_WIDTH.
REQ-004 Parameter RAM_BASE, 16'h0400, first frame RAM register address.
REQ-005 Parameter STATUS_REG, 16'h8000, status register address.
REQ-006 Parameter POLL_CYCLES, 100000, clock cycles between status polls.
REQ-007 Parameter TIMEOUT_CYCLES, 1000000, read watchdog limit (see REQ-026).
REQ-008 i_clk in 1, clock; i_rst in 1, reset, synchronous, active-high.
REQ-009 i_enable in 1, run sequencer while high.
REQ-010 o_cmd_valid out 1, o_cmd_we out 1, o_cmd_sccb_mode out 1, o_cmd_addr_slave out 7, o_cmd_addr_reg out 16, o_cmd_burst_num out BURST_WIDTH, i_cmd_ready in 1: command FIFO push port.
REQ-011 o_wr_valid out 1, o_wr_data out 16, i_wr_ready in 1: write-word FIFO push port.
REQ-012 i_rd_valid in 1, i_rd_data in 16, o_rd_ready out 1: read-word FIFO pop port.
REQ-013 o_pix_valid out 1, o_pix_addr out 10, o_pix_data out 16: frame word stream; o_frame_done out 1 pulse; o_subpage out 1; o_busy out 1; o_timeout_err out 1 sticky.

Function
REQ-014 States: IDLE, POLL_WAIT, STAT_REQ, STAT_RD, BURST_REQ, BURST_RD, CLR_REQ, CLR_WR, DONE.
REQ-015 IDLE -> POLL_WAIT when i_enable=1; any state other than IDLE SHALL return to IDLE on the cycle after i_enable=0 is sampled in POLL_WAIT or DONE only (transactions in flight complete).
REQ-016 POLL_WAIT: counter loads POLL_CYCLES-1, decrements each cycle; at 0 -> STAT_REQ.
REQ-017 STAT_REQ: o_cmd_valid=1, we=0, addr_reg=STATUS_REG, burst_num=0; transfer on o_cmd_valid&i_cmd_ready -> STAT_RD.
REQ-018 STAT_RD: o_rd_ready=1; on i_rd_valid capture status; bit3=0 -> POLL_WAIT; bit3=1 -> latch o_subpage=bit0, clear word counter, -> BURST_REQ.
REQ-019 BURST_REQ: o_cmd_valid=1, we=0, addr_reg=RAM_BASE+word counter, burst_num=all ones; transfer -> BURST_RD.
REQ-020 BURST_RD: o_rd_ready=1; each i_rd_valid word SHALL appear the next cycle on o_pix_valid=1, o_pix_addr=word counter, o_pix_data=word; counter increments by 1.
REQ-021 After 2^BURST_WIDTH words: counter==FRAME_WORDS -> CLR_REQ, else -> BURST_REQ.
REQ-022 CLR_REQ: o_cmd_valid=1, we=1, addr_reg=STATUS_REG, burst_num=0; transfer -> CLR_WR.
REQ-023 CLR_WR: o_wr_valid=1, o_wr_data=captured status with bit3 cleared; transfer on i_wr_ready -> DONE.
REQ-024 DONE: o_frame_done=1 for exactly one cycle -> POLL_WAIT.
REQ-025 o_cmd_sccb_mode=0 and o_cmd_addr_slave=SLAVE_ADDR constantly; o_busy=1 in every state except IDLE and POLL_WAIT; o_cmd_valid/o_wr_valid SHALL hold stable until accepted.

Configuration
REQ-026 Macro MLX_SEQ_TIMEOUT_EN defined: watchdog counts cycles in STAT_RD/BURST_RD without i_rd_valid, clears on each word; reaching TIMEOUT_CYCLES sets o_timeout_err=1 (until reset) and forces POLL_WAIT, no o_frame_done. Undefined: no watchdog, states wait indefinitely, o_timeout_err tied 0.

Reset
REQ-027 i_rst=1 at any edge, including mid-burst: state IDLE, all counters 0, o_subpage=0, o_timeout_err=0, every valid/ready/pulse output 0 next cycle.
REQ-028 A partially read frame SHALL NOT produce o_frame_done after reset.

Verification
REQ-029 Enable, status returns 16'h0000 -> no burst command, next STAT_REQ after POLL_CYCLES.
REQ-030 Status 16'h0009 -> o_subpage=1, 52 burst commands addr 0x0400,0x0410..0x0730, 832 o_pix_valid with addr 0..831, write 16'h0001, one o_frame_done.
REQ-031 i_cmd_ready low 20 cycles during BURST_REQ -> command fields stable, no skipped address.
REQ-032 i_rst asserted after 100 pixels -> outputs 0 next cycle; after re-enable frame restarts at addr 0.
REQ-033 MLX_SEQ_TIMEOUT_EN, rd stalls TIMEOUT_CYCLES in BURST_RD -> o_timeout_err=1, POLL_WAIT, no o_frame_done.
REQ-034 i_rd_valid gaps of random length in BURST_RD -> o_pix_data matches input order exactly.

Source files
------------

// File: rtl/mlx_frame_sequencer.sv
// Frame sequencer for an MLX-style thermal sensor behind a command/word FIFO I2C master.
// Optional read watchdog is enabled by defining MLX_SEQ_TIMEOUT_EN.
module mlx_frame_sequencer #(
    parameter logic [6:0]  SLAVE_ADDR     = 7'h33,
    parameter int          BURST_WIDTH    = 4,
    parameter int          FRAME_WORDS    = 832,
    parameter logic [15:0] RAM_BASE       = 16'h0400,
    parameter logic [15:0] STATUS_REG     = 16'h8000,
    parameter int          POLL_CYCLES    = 100000,
    parameter int          TIMEOUT_CYCLES = 1000000
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_enable,
    output logic                   o_cmd_valid,
    output logic                   o_cmd_we,
    output logic                   o_cmd_sccb_mode,
    output logic [6:0]             o_cmd_addr_slave,
    output logic [15:0]            o_cmd_addr_reg,
    output logic [BURST_WIDTH-1:0] o_cmd_burst_num,
    input  logic                   i_cmd_ready,
    output logic                   o_wr_valid,
    output logic [15:0]            o_wr_data,
    input  logic                   i_wr_ready,
    input  logic                   i_rd_valid,
    input  logic [15:0]            i_rd_data,
    output logic                   o_rd_ready,
    output logic                   o_pix_valid,
    output logic [9:0]             o_pix_addr,
    output logic [15:0]            o_pix_data,
    output logic                   o_frame_done,
    output logic                   o_subpage,
    output logic                   o_busy,
    output logic                   o_timeout_err
);

    localparam int WCW = $clog2(FRAME_WORDS + 1);
    localparam int PCW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;

    // Elaboration-time sanity checks on the configuration.
    if ((FRAME_WORDS % (2 ** BURST_WIDTH)) != 0) begin : g_bad_frame_words
        $error("FRAME_WORDS must be a multiple of the burst length");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_POLL_WAIT = 4'd1,
        ST_STAT_REQ  = 4'd2,
        ST_STAT_RD   = 4'd3,
        ST_BURST_REQ = 4'd4,
        ST_BURST_RD  = 4'd5,
        ST_CLR_REQ   = 4'd6,
        ST_CLR_WR    = 4'd7,
        ST_DONE      = 4'd8
    } state_t;

    state_t                 state_r;
    state_t                 state_s;
    logic [PCW-1:0]         poll_cnt_r;
    logic [WCW-1:0]         word_cnt_r;
    logic [BURST_WIDTH-1:0] burst_cnt_r;
    logic [15:0]            status_r;
    logic                   subpage_r;
    logic                   pix_valid_r;
    logic [9:0]             pix_addr_r;
    logic [15:0]            pix_data_r;
    logic                   timeout_s;
    logic                   burst_last_s;

    assign burst_last_s = (burst_cnt_r == {BURST_WIDTH{1'b1}});

`ifdef MLX_SEQ_TIMEOUT_EN
    localparam int TCW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TCW-1:0] wd_cnt_r;
    logic           timeout_err_r;
    logic           rd_wait_s;

    assign rd_wait_s = ((state_r == ST_STAT_RD) || (state_r == ST_BURST_RD)) && !i_rd_valid;
    assign timeout_s = rd_wait_s && (wd_cnt_r == TCW'(TIMEOUT_CYCLES - 1));

    // Watchdog: counts consecutive stalled read cycles; error flag is sticky until reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wd_cnt_r      <= '0;
            timeout_err_r <= 1'b0;
        end else if (timeout_s) begin
            wd_cnt_r      <= '0;
            timeout_err_r <= 1'b1;
        end else if (rd_wait_s) begin
            wd_cnt_r      <= wd_cnt_r + TCW'(1);
        end else begin
            wd_cnt_r      <= '0;
        end
    end

    assign o_timeout_err = timeout_err_r;
`else
    assign timeout_s     = 1'b0;
    assign o_timeout_err = 1'b0;
`endif

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; disable is only honoured between frames (POLL_WAIT / DONE).
    always_comb begin
        state_s = state_r;
        unique case (state_r)
            ST_IDLE: begin
                if (i_enable) state_s = ST_POLL_WAIT;
                else          state_s = ST_IDLE;
            end
            ST_POLL_WAIT: begin
                if (!i_enable)                  state_s = ST_IDLE;
                else if (poll_cnt_r == PCW'(0)) state_s = ST_STAT_REQ;
                else                            state_s = ST_POLL_WAIT;
            end
            ST_STAT_REQ: begin
                if (i_cmd_ready) state_s = ST_STAT_RD;
                else             state_s = ST_STAT_REQ;
            end
            ST_STAT_RD: begin
                if (i_rd_valid)     state_s = i_rd_data[3] ? ST_BURST_REQ : ST_POLL_WAIT;
                else if (timeout_s) state_s = ST_POLL_WAIT;
                else                state_s = ST_STAT_RD;
            end
            ST_BURST_REQ: begin
                if (i_cmd_ready) state_s = ST_BURST_RD;
                else             state_s = ST_BURST_REQ;
            end
            ST_BURST_RD: begin
                if (i_rd_valid && burst_last_s)
                    state_s = (word_cnt_r == WCW'(FRAME_WORDS - 1)) ? ST_CLR_REQ : ST_BURST_REQ;
                else if (timeout_s)
                    state_s = ST_POLL_WAIT;
                else
                    state_s = ST_BURST_RD;
            end
            ST_CLR_REQ: begin
                if (i_cmd_ready) state_s = ST_CLR_WR;
                else             state_s = ST_CLR_REQ;
            end
            ST_CLR_WR: begin
                if (i_wr_ready) state_s = ST_DONE;
                else            state_s = ST_CLR_WR;
            end
            ST_DONE: begin
                if (i_enable) state_s = ST_POLL_WAIT;
                else          state_s = ST_IDLE;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Datapath: poll timer, word/burst counters, status capture and pixel stream register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            poll_cnt_r  <= '0;
            word_cnt_r  <= '0;
            burst_cnt_r <= '0;
            status_r    <= 16'h0000;
            subpage_r   <= 1'b0;
            pix_valid_r <= 1'b0;
            pix_addr_r  <= 10'd0;
            pix_data_r  <= 16'h0000;
        end else begin
            pix_valid_r <= 1'b0;
            if ((state_s == ST_POLL_WAIT) && (state_r != ST_POLL_WAIT)) begin
                poll_cnt_r <= PCW'(POLL_CYCLES - 1);
            end else if ((state_r == ST_POLL_WAIT) && (poll_cnt_r != PCW'(0))) begin
                poll_cnt_r <= poll_cnt_r - PCW'(1);
            end
            if ((state_r == ST_STAT_RD) && i_rd_valid) begin
                status_r <= i_rd_data;
                if (i_rd_data[3]) begin
                    subpage_r   <= i_rd_data[0];
                    word_cnt_r  <= '0;
                    burst_cnt_r <= '0;
                end
            end
            if ((state_r == ST_BURST_RD) && i_rd_valid) begin
                pix_valid_r <= 1'b1;
                pix_addr_r  <= 10'(word_cnt_r);
                pix_data_r  <= i_rd_data;
                word_cnt_r  <= word_cnt_r + WCW'(1);
                burst_cnt_r <= burst_cnt_r + BURST_WIDTH'(1);
            end
        end
    end

    // Handshake outputs decoded from the state register so they hold until accepted.
    always_comb begin
        o_cmd_valid     = 1'b0;
        o_cmd_we        = 1'b0;
        o_cmd_addr_reg  = STATUS_REG;
        o_cmd_burst_num = {BURST_WIDTH{1'b0}};
        o_wr_valid      = 1'b0;
        o_rd_ready      = 1'b0;
        o_frame_done    = 1'b0;
        o_busy          = 1'b1;
        unique case (state_r)
            ST_IDLE, ST_POLL_WAIT: o_busy = 1'b0;
            ST_STAT_REQ:           o_cmd_valid = 1'b1;
            ST_STAT_RD, ST_BURST_RD: o_rd_ready = 1'b1;
            ST_BURST_REQ: begin
                o_cmd_valid     = 1'b1;
                o_cmd_addr_reg  = RAM_BASE + 16'(word_cnt_r);
                o_cmd_burst_num = {BURST_WIDTH{1'b1}};
            end
            ST_CLR_REQ: begin
                o_cmd_valid = 1'b1;
                o_cmd_we    = 1'b1;
            end
            ST_CLR_WR: o_wr_valid   = 1'b1;
            ST_DONE:   o_frame_done = 1'b1;
            default:   o_busy       = 1'b0;
        endcase
    end

    assign o_cmd_sccb_mode  = 1'b0;
    assign o_cmd_addr_slave = SLAVE_ADDR;
    assign o_wr_data        = status_r & 16'hFFF7;
    assign o_subpage        = subpage_r;
    assign o_pix_valid      = pix_valid_r;
    assign o_pix_addr       = pix_addr_r;
    assign o_pix_data       = pix_data_r;

endmodule
